// File: rtl/debounce_sync.sv
// Debounces a raw asynchronous input: 2-flop synchronizer, stability counter and
// a 4-state FSM producing a clean level plus single-cycle rise/fall pulses.
module debounce_sync #(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic qbar,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             q_q, q_d;
    logic             qbar_q, qbar_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        s1_d    = din;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            LOW: begin
                if (s2_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                // A return to the old level wins over a count that would complete.
                if (!s2_q) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s2_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s2_q) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
                q_d     = 1'b0;
            end
        endcase

        qbar_d = ~q_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            qbar_q  <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qbar_q  <= qbar_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q    = q_q;
    assign qbar = qbar_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: each scenario pushes the rise/fall events it expects
// (edge number, direction) and a negedge monitor pops and compares them.
module tb_debounce_sync;

    localparam int STABLE = 8;
    localparam int LAT    = STABLE + 1;

    typedef struct {
        int at_edge;
        bit is_rise;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic din   = 1'b0;
    logic q, qbar, rise, fall;

    int total    = 0;
    int bad      = 0;
    int edge_cnt = 0;
    ev_t exp_q[$];

    debounce_sync #(.STABLE_CYCLES(STABLE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .q    (q),
        .qbar (qbar),
        .rise (rise),
        .fall (fall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: complement, exclusivity, and every pulse matched against the scoreboard.
    always @(negedge clk) begin
        ev_t ev;
        total++;
        if (qbar !== ~q) begin
            bad++;
            $display("[TB] FAIL complement edge=%0d q=%b qbar=%b want qbar=%b", edge_cnt, q, qbar, ~q);
        end
        total++;
        if (rise === 1'b1 && fall === 1'b1) begin
            bad++;
            $display("[TB] FAIL exclusive edge=%0d rise=%b fall=%b want not both", edge_cnt, rise, fall);
        end
        if (rise === 1'b1 || fall === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_pulse edge=%0d rise=%b fall=%b want none", edge_cnt, rise, fall);
            end else begin
                ev = exp_q.pop_front();
                if (ev.at_edge != edge_cnt || ev.is_rise !== rise) begin
                    bad++;
                    $display("[TB] FAIL pulse_timing got edge=%0d rise=%b want edge=%0d rise=%b",
                             edge_cnt, rise, ev.at_edge, ev.is_rise);
                end
                total++;
                if (q !== rise) begin
                    bad++;
                    $display("[TB] FAIL pulse_level edge=%0d q=%b want %b", edge_cnt, q, rise);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_ev(input int at_edge, input bit is_rise);
        ev_t ev;
        ev.at_edge = at_edge;
        ev.is_rise = is_rise;
        exp_q.push_back(ev);
    endtask

    task automatic wait_events(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s_timeout pending=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_level(input string name, input logic want);
        total++;
        if (q !== want || qbar !== ~want) begin
            bad++;
            $display("[TB] FAIL %s q=%b qbar=%b want q=%b", name, q, qbar, want);
        end
    endtask

    task automatic test_reset();
        int k;
        din = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (q !== 1'b0 || qbar !== 1'b1 || rise !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_hold q=%b qbar=%b rise=%b want 0 1 0", q, qbar, rise);
            end
        end
        rst_n = 1'b1;
        k = edge_cnt + 1;
        push_ev(k + LAT, 1'b1);
        while (edge_cnt < k + LAT - 1) step();
        check_level("reset_before_latency", 1'b0);
        step();
        check_level("reset_after_latency", 1'b1);
        wait_events(5, "reset");
    endtask

    task automatic test_clean_rise_fall();
        int k;
        din = 1'b0;
        push_ev(edge_cnt + 1 + LAT, 1'b0);
        wait_events(20, "clean_setup");
        din = 1'b1;
        k = edge_cnt + 1;
        push_ev(k + LAT, 1'b1);
        for (int i = 0; i < 20; i++) step();
        check_level("clean_high", 1'b1);
        din = 1'b0;
        k = edge_cnt + 1;
        push_ev(k + LAT, 1'b0);
        wait_events(20, "clean_fall");
        step();
        check_level("clean_low", 1'b0);
    endtask

    task automatic test_glitch();
        din = 1'b1;
        for (int i = 0; i < 3; i++) step();
        din = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            check_level("glitch_hold", 1'b0);
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pattern;
        int last_k;
        pattern = 6'b101101;
        last_k = 0;
        for (int i = 5; i >= 0; i--) begin
            din = pattern[i];
            last_k = edge_cnt + 1;
            step();
        end
        push_ev(last_k + LAT, 1'b1);
        wait_events(30, "bounce");
        step();
        check_level("bounce_high", 1'b1);
    endtask

    task automatic test_boundary();
        int k;
        din = 1'b0;
        for (int i = 0; i < STABLE - 1; i++) step();
        din = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check_level("boundary_7_low_cycles", 1'b1);
        din = 1'b0;
        k = edge_cnt + 1;
        for (int i = 0; i < STABLE; i++) step();
        din = 1'b1;
        push_ev(k + LAT, 1'b0);
        push_ev(k + STABLE + LAT, 1'b1);
        wait_events(30, "boundary_8_low_cycles");
        check_level("boundary_recovered", 1'b1);
    endtask

    task automatic test_reset_mid_wait();
        int k;
        din = 1'b0;
        push_ev(edge_cnt + 1 + LAT, 1'b0);
        wait_events(20, "mid_setup");
        din = 1'b1;
        k = edge_cnt + 1;
        while (edge_cnt < k + 5) step();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (q !== 1'b0 || qbar !== 1'b1 || rise !== 1'b0 || fall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset_values q=%b qbar=%b rise=%b fall=%b want 0 1 0 0", q, qbar, rise, fall);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        k = edge_cnt + 1;
        push_ev(k + LAT, 1'b1);
        while (edge_cnt < k + LAT - 1) step();
        check_level("mid_restart_before", 1'b0);
        wait_events(5, "mid_restart");
        check_level("mid_restart_after", 1'b1);
    endtask

    initial begin
        $display("[TB] starting debounce_sync bench");
        test_reset();
        test_clean_rise_fall();
        test_glitch();
        test_bounce();
        test_boundary();
        test_reset_mid_wait();
        for (int i = 0; i < 12; i++) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
